// File: rtl/key_multi_debounce.sv
// key_multi_debounce: N-channel active-low key debouncer with press/release/long-press pulses and level output.
// Define KEY_REPEAT_EN to add auto-repeat key_vld pulses after a long press.
module key_multi_debounce #(
    parameter int KEY_NUM    = 4,
    parameter int T_DEBOUNCE = 2_000_000,
    parameter int T_LONG     = 100_000_000,
    parameter int T_REPEAT   = 20_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] key,
    output logic [KEY_NUM-1:0] key_vld,
    output logic [KEY_NUM-1:0] key_rel,
    output logic [KEY_NUM-1:0] key_long,
    output logic [KEY_NUM-1:0] key_state
);
    localparam int T_MAX = (T_LONG > T_DEBOUNCE) ? ((T_LONG > T_REPEAT) ? T_LONG : T_REPEAT)
                                                 : ((T_DEBOUNCE > T_REPEAT) ? T_DEBOUNCE : T_REPEAT);
    localparam int CNT_W = $clog2(T_MAX);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(T_DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(T_LONG - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(T_REPEAT - 1);
`endif

    typedef enum logic [1:0] {IDLE, DOWN_FILT, HELD, UP_FILT} state_t;

    logic [KEY_NUM-1:0] s1_q, s2_q;

    always_ff @(posedge clk) begin
        s1_q <= rst ? '1 : key;
        s2_q <= rst ? '1 : s1_q;
    end

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        state_t st_q, st_d;
        logic [CNT_W-1:0] cnt_q, cnt_d, hold_q, hold_d;
        logic long_q, long_d, vld_q, vld_d, rel_q, rel_d, lng_q, lng_d, lvl_q, lvl_d;
`ifdef KEY_REPEAT_EN
        logic [CNT_W-1:0] rep_q, rep_d;
`endif

        always_comb begin
            st_d   = st_q;
            cnt_d  = '0;
            hold_d = hold_q;
            long_d = long_q;
            vld_d  = 1'b0;
            rel_d  = 1'b0;
            lng_d  = 1'b0;
`ifdef KEY_REPEAT_EN
            rep_d  = rep_q;
`endif
            case (st_q)
                IDLE: st_d = s2_q[i] ? IDLE : DOWN_FILT;
                DOWN_FILT: begin
                    cnt_d = cnt_q + ONE;
                    if (s2_q[i]) begin
                        st_d  = IDLE;
                        cnt_d = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        st_d  = HELD;
                        cnt_d = '0;
                        vld_d = 1'b1;
                    end
                end
                HELD: begin
                    // long detection runs before the release check so both can happen together
                    hold_d = (hold_q == LONG_LAST) ? hold_q : hold_q + ONE;
                    lng_d  = (hold_q == LONG_LAST) && !long_q;
                    long_d = long_q | lng_d;
`ifdef KEY_REPEAT_EN
                    if (long_q) begin
                        rep_d = (rep_q == REP_LAST) ? '0 : rep_q + ONE;
                        vld_d = rep_q == REP_LAST;
                    end
`endif
                    st_d = s2_q[i] ? UP_FILT : HELD;
                end
                UP_FILT: begin
                    cnt_d = cnt_q + ONE;
                    if (!s2_q[i]) begin
                        st_d  = HELD;
                        cnt_d = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        st_d   = IDLE;
                        cnt_d  = '0;
                        rel_d  = 1'b1;
                        hold_d = '0;
                        long_d = 1'b0;
`ifdef KEY_REPEAT_EN
                        rep_d  = '0;
`endif
                    end
                end
                default: st_d = IDLE;
            endcase
            lvl_d = (st_d == HELD) || (st_d == UP_FILT);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                st_q   <= IDLE;
                cnt_q  <= '0;
                hold_q <= '0;
                long_q <= 1'b0;
                vld_q  <= 1'b0;
                rel_q  <= 1'b0;
                lng_q  <= 1'b0;
                lvl_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
                rep_q  <= '0;
`endif
            end else begin
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                hold_q <= hold_d;
                long_q <= long_d;
                vld_q  <= vld_d;
                rel_q  <= rel_d;
                lng_q  <= lng_d;
                lvl_q  <= lvl_d;
`ifdef KEY_REPEAT_EN
                rep_q  <= rep_d;
`endif
            end
        end

        assign key_vld[i]   = vld_q;
        assign key_rel[i]   = rel_q;
        assign key_long[i]  = lng_q;
        assign key_state[i] = lvl_q;
    end
endmodule

// File: tb/tb_key_multi_debounce.sv
// tb_key_multi_debounce: scoreboard bench for key_multi_debounce with short sim timings.
module tb_key_multi_debounce;
    localparam int N  = 4;
    localparam int TD = 10;
    localparam int TL = 50;
    localparam int TR = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] key = '1;
    logic [N-1:0] key_vld, key_rel, key_long, key_state;
    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;

    typedef struct {
        int         cyc;
        logic [3:0] v;
        logic [3:0] r;
        logic [3:0] l;
    } ev_t;
    ev_t exp_q[$];

    key_multi_debounce #(
        .KEY_NUM(N), .T_DEBOUNCE(TD), .T_LONG(TL), .T_REPEAT(TR)
    ) dut (
        .clk(clk), .rst(rst), .key(key),
        .key_vld(key_vld), .key_rel(key_rel), .key_long(key_long), .key_state(key_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [3:0] v, input logic [3:0] r, input logic [3:0] l);
        ev_t e;
        e.cyc = c;
        e.v = v;
        e.r = r;
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic watch(input int n);
        ev_t e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL missed_event cyc=%0d got none required vld=%b rel=%b long=%b", e.cyc, e.v, e.r, e.l);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                checks++;
                if ({key_vld, key_rel, key_long} !== {e.v, e.r, e.l}) begin
                    failures++;
                    $display("FAIL event cyc=%0d got vld=%b rel=%b long=%b required vld=%b rel=%b long=%b",
                             cyc, key_vld, key_rel, key_long, e.v, e.r, e.l);
                end
            end else if ((key_vld | key_rel | key_long) !== 4'b0) begin
                checks++;
                failures++;
                $display("FAIL spurious cyc=%0d got vld=%b rel=%b long=%b required 0", cyc, key_vld, key_rel, key_long);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        key = '1;
        repeat (3) @(negedge clk);
        checks += 4;
        if (key_vld !== 4'b0) begin failures++; $display("FAIL reset_vld got %b required 0000", key_vld); end
        if (key_rel !== 4'b0) begin failures++; $display("FAIL reset_rel got %b required 0000", key_rel); end
        if (key_long !== 4'b0) begin failures++; $display("FAIL reset_long got %b required 0000", key_long); end
        if (key_state !== 4'b0) begin failures++; $display("FAIL reset_state got %b required 0000", key_state); end
        rst = 1'b0;
        watch(5);
    endtask

    task automatic test_press;
        key[0] = 1'b0;
        push(cyc + TD + 3, 4'b0001, 4'b0, 4'b0);
        watch(TD + 5);
        checks++;
        if (key_state !== 4'b0001) begin failures++; $display("FAIL press_state got %b required 0001", key_state); end
        key[0] = 1'b1;
        push(cyc + TD + 3, 4'b0, 4'b0001, 4'b0);
        watch(TD + 5);
        checks++;
        if (key_state !== 4'b0) begin failures++; $display("FAIL press_rel_state got %b required 0000", key_state); end
    endtask

    task automatic test_bounce;
        key[1] = 1'b0;
        watch(5);
        key[1] = 1'b1;
        watch(3);
        key[1] = 1'b0;
        push(cyc + TD + 3, 4'b0010, 4'b0, 4'b0);
        watch(TD + 6);
        checks++;
        if (key_state !== 4'b0010) begin failures++; $display("FAIL bounce_state got %b required 0010", key_state); end
        key[1] = 1'b1;
        push(cyc + TD + 3, 4'b0, 4'b0010, 4'b0);
        watch(TD + 5);
    endtask

    task automatic test_long;
        int c0;
        c0 = cyc;
        key[2] = 1'b0;
        push(c0 + TD + 3, 4'b0100, 4'b0, 4'b0);
        push(c0 + TD + 3 + TL, 4'b0, 4'b0, 4'b0100);
`ifdef KEY_REPEAT_EN
        for (int t = c0 + TD + 3 + TL + TR; t <= c0 + 83; t += TR) push(t, 4'b0100, 4'b0, 4'b0);
`endif
        watch(80);
        checks++;
        if (key_state !== 4'b0100) begin failures++; $display("FAIL long_state got %b required 0100", key_state); end
        key[2] = 1'b1;
        push(cyc + TD + 3, 4'b0, 4'b0100, 4'b0);
        watch(TD + 6);
    endtask

    task automatic test_release_bounce;
        key[3] = 1'b0;
        push(cyc + TD + 3, 4'b1000, 4'b0, 4'b0);
        watch(TD + 5);
        key[3] = 1'b1;
        watch(4);
        key[3] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            watch(1);
            checks++;
            if (key_state !== 4'b1000) begin failures++; $display("FAIL relbounce_state cyc=%0d got %b required 1000", cyc, key_state); end
        end
        key[3] = 1'b1;
        push(cyc + TD + 3, 4'b0, 4'b1000, 4'b0);
        watch(TD + 5);
    endtask

    task automatic test_all_keys;
        key = 4'b0000;
        push(cyc + TD + 3, 4'b1111, 4'b0, 4'b0);
        watch(TD + 5);
        checks++;
        if (key_state !== 4'b1111) begin failures++; $display("FAIL all_state got %b required 1111", key_state); end
        key = 4'b1111;
        push(cyc + TD + 3, 4'b0, 4'b1111, 4'b0);
        watch(TD + 5);
        checks++;
        if (key_state !== 4'b0) begin failures++; $display("FAIL all_rel_state got %b required 0000", key_state); end
    endtask

    task automatic test_reset_mid;
        key[0] = 1'b0;
        watch(9);
        rst = 1'b1;
        watch(1);
        checks++;
        if ({key_vld, key_rel, key_long, key_state} !== 16'b0) begin
            failures++;
            $display("FAIL midrst_outputs got vld=%b rel=%b long=%b state=%b required 0", key_vld, key_rel, key_long, key_state);
        end
        rst = 1'b0;
        push(cyc + TD + 3, 4'b0001, 4'b0, 4'b0);
        watch(TD + 5);
        checks++;
        if (key_state !== 4'b0001) begin failures++; $display("FAIL midrst_state got %b required 0001", key_state); end
        key[0] = 1'b1;
        push(cyc + TD + 3, 4'b0, 4'b0001, 4'b0);
        watch(TD + 5);
    endtask

    initial begin
        test_reset;
        test_press;
        test_bounce;
        test_long;
        test_release_bounce;
        test_all_keys;
        test_reset_mid;
        watch(3);
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL leftover_events got %0d required 0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
